// File: rtl/mem_lsu_stage_pkg.sv
// Shared constants for the memory stage: access size codes, default geometry,
// FSM state encoding and the WB latch field width.
package mem_lsu_stage_pkg;

    localparam int LSU_DBITS        = 32;
    localparam int LSU_DMEMWORDS    = 2048;
    localparam int LSU_DMEMADDRBITS = $clog2(LSU_DMEMWORDS);
    localparam int LSU_REGBITS      = 5;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_state_e;

    // valid, rd, wr_reg, misalign, is_ld, size, uns, lane, result, pc
    function automatic int wb_bits(input int dbits, input int regbits);
        return 1 + regbits + 1 + 1 + 1 + 2 + 1 + 2 + 2 * dbits;
    endfunction

    localparam int LSU_WB_BITS = wb_bits(LSU_DBITS, LSU_REGBITS);

endpackage

// File: rtl/mem_lsu_stage_lane_align.sv
// Combinational byte-lane logic: store byte enables and data replication,
// load lane extraction with sign/zero extension, and misalign detection.
module lsu_lane_align
    import mem_lsu_stage_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_lane_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    output logic        misalign_o,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_uns_i,
    input  logic [1:0]  ld_lane_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_val_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Reserved size 2'b11 falls into the word branch.
    always_comb begin
        st_be_o    = 4'hF;
        st_wdata_o = st_wdata_i;
        misalign_o = 1'b0;
        case (st_size_i)
            SZ_B: begin
                st_be_o    = 4'b0001 << st_lane_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            SZ_H: begin
                st_be_o    = st_lane_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_wdata_i[15:0]}};
                misalign_o = st_lane_i[0];
            end
            default: misalign_o = (st_lane_i != 2'b00);
        endcase
    end

    always_comb begin
        ld_byte  = ld_word_i[8*ld_lane_i +: 8];
        ld_half  = ld_word_i[16*ld_lane_i[1] +: 16];
        ld_val_o = ld_word_i;
        case (ld_size_i)
            SZ_B:    ld_val_o = {{24{ld_byte[7] & ~ld_uns_i}}, ld_byte};
            SZ_H:    ld_val_o = {{16{ld_half[15] & ~ld_uns_i}}, ld_half};
            default: ld_val_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu_stage.sv
// Memory stage between AGEX and WB: byte/half/word loads and stores, RD_LAT-cycle
// loads with stall handshake, misalign faults. MEM_PERF_CNT_EN adds perf counters.
module mem_lsu_stage
    import mem_lsu_stage_pkg::*;
#(
    parameter int DBITS     = LSU_DBITS,
    parameter int DMEMWORDS = LSU_DMEMWORDS,
    parameter int RD_LAT    = 1,
    parameter int REGBITS   = LSU_REGBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_is_ld,
    input  logic               in_is_st,
    input  logic [1:0]         in_size,
    input  logic               in_uns,
    input  logic [DBITS-1:0]   in_addr,
    input  logic [DBITS-1:0]   in_wdata,
    input  logic [REGBITS-1:0] in_rd,
    input  logic               in_wr_reg,
    input  logic [DBITS-1:0]   in_result,
    input  logic [DBITS-1:0]   in_pc,
    output logic               out_valid,
    output logic [REGBITS-1:0] out_rd,
    output logic               out_wr_reg,
    output logic [DBITS-1:0]   out_val,
    output logic [DBITS-1:0]   out_pc,
    output logic               out_misalign,
    output logic [REGBITS-1:0] fwd_rd,
    output logic               fwd_wr,
`ifdef MEM_PERF_CNT_EN
    output logic [31:0]        ld_cnt,
    output logic [31:0]        st_cnt,
    output logic [31:0]        stall_cnt,
`endif
    output logic               fwd_busy
);

    localparam int AW = $clog2(DMEMWORDS);
    localparam int CW = 2;

    typedef struct packed {
        logic               valid;
        logic [REGBITS-1:0] rd;
        logic               wr_reg;
        logic               misalign;
        logic               is_ld;
        logic [1:0]         size;
        logic               uns;
        logic [1:0]         lane;
        logic [DBITS-1:0]   result;
        logic [DBITS-1:0]   pc;
    } wb_t;

    lsu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    wb_t              wb_q, wb_d, hold_q, hold_d, entry;
    logic [AW-1:0]    idx_q, idx_d, widx;
    logic [DBITS-1:0] mem_q [DMEMWORDS];

    logic             accept, is_ld, is_st, misalign, mem_fault, st_fire, ld_fire;
    logic [3:0]       st_be;
    logic [DBITS-1:0] st_wdata, ld_word, ld_val;
    logic             unused_addr;

    assign in_ready    = !reset && (state_q == ST_IDLE);
    assign accept      = in_valid && in_ready;
    assign is_st       = in_is_st;
    assign is_ld       = in_is_ld && !in_is_st;
    assign mem_fault   = (is_ld || is_st) && misalign;
    assign st_fire     = accept && is_st && !misalign;
    assign ld_fire     = accept && is_ld && !misalign;
    assign widx        = in_addr[AW+1:2];
    assign unused_addr = ^in_addr[DBITS-1:AW+2];
    assign ld_word     = mem_q[idx_q];

    lsu_lane_align u_align (
        .st_size_i  (in_size),
        .st_lane_i  (in_addr[1:0]),
        .st_wdata_i (in_wdata),
        .st_be_o    (st_be),
        .st_wdata_o (st_wdata),
        .misalign_o (misalign),
        .ld_size_i  (wb_q.size),
        .ld_uns_i   (wb_q.uns),
        .ld_lane_i  (wb_q.lane),
        .ld_word_i  (ld_word),
        .ld_val_o   (ld_val)
    );

    always_comb begin
        entry          = '0;
        entry.valid    = 1'b1;
        entry.rd       = in_rd;
        entry.wr_reg   = in_wr_reg && !is_st && !mem_fault;
        entry.misalign = mem_fault;
        entry.is_ld    = is_ld && !misalign;
        entry.size     = in_size;
        entry.uns      = in_uns;
        entry.lane     = in_addr[1:0];
        entry.result   = (is_ld || is_st) ? '0 : in_result;
        entry.pc       = in_pc;
    end

    // A load parks in hold_q while WAIT counts down; the registered index stays put.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        wb_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (ld_fire) begin
                        idx_d = widx;
                    end
                    if (ld_fire && (RD_LAT > 1)) begin
                        hold_d  = entry;
                        cnt_d   = CW'(RD_LAT - 1);
                        state_d = ST_WAIT;
                    end else begin
                        wb_d = entry;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    wb_d    = hold_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wb_q    <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
        end
    end

    // st_fire is already blocked during reset through in_ready.
    always_ff @(posedge clk) begin
        if (st_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) begin
                    mem_q[widx][8*b +: 8] <= st_wdata[8*b +: 8];
                end
            end
        end
    end

    assign out_valid    = wb_q.valid;
    assign out_rd       = wb_q.rd;
    assign out_wr_reg   = wb_q.wr_reg;
    assign out_misalign = wb_q.misalign;
    assign out_pc       = wb_q.pc;
    assign out_val      = wb_q.is_ld ? ld_val : wb_q.result;

    always_comb begin
        fwd_rd   = '0;
        fwd_wr   = 1'b0;
        fwd_busy = 1'b0;
        if (reset) begin
            fwd_busy = 1'b0;
        end else if (state_q == ST_WAIT) begin
            fwd_rd   = hold_q.rd;
            fwd_wr   = hold_q.wr_reg;
            fwd_busy = 1'b1;
        end else if (in_valid) begin
            fwd_rd = in_rd;
            fwd_wr = entry.wr_reg;
        end
    end

`ifdef MEM_PERF_CNT_EN
    logic [31:0] ld_cnt_q, st_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_cnt_q    <= '0;
            st_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept && is_ld)       ld_cnt_q    <= ld_cnt_q + 32'd1;
            if (accept && is_st)       st_cnt_q    <= st_cnt_q + 32'd1;
            if (in_valid && !in_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign ld_cnt    = ld_cnt_q;
    assign st_cnt    = st_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Bench for mem_lsu_stage: instances with RD_LAT 1, 3 and 4 share one driver;
// sel routes in_valid to one of them and picks which outputs the monitor watches.
`timescale 1ns/1ps
module tb_mem_lsu_stage;

    localparam int N  = 3;
    localparam int KA = 0;
    localparam int KL = 1;
    localparam int KS = 2;
    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    endfunction

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_is_ld = 1'b0, in_is_st = 1'b0, in_uns = 1'b0, in_wr_reg = 1'b0;
    logic [1:0]  in_size = 2'b00;
    logic [31:0] in_addr = '0, in_wdata = '0, in_result = '0, in_pc = '0;
    logic [4:0]  in_rd = '0;
    int          sel = 0;

    logic        o_ready [N];
    logic        o_valid [N];
    logic        o_wr    [N];
    logic        o_mis   [N];
    logic        o_fwr   [N];
    logic        o_busy  [N];
    logic [4:0]  o_rd    [N];
    logic [4:0]  o_frd   [N];
    logic [31:0] o_val   [N];
    logic [31:0] o_pc    [N];
`ifdef MEM_PERF_CNT_EN
    logic [31:0] o_ldc   [N];
    logic [31:0] o_stc   [N];
    logic [31:0] o_stall [N];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_lsu_stage #(.RD_LAT(lat_of(g))) u_dut (
            .clk          (clk),
            .reset        (reset),
            .in_valid     (in_valid && (sel == g)),
            .in_ready     (o_ready[g]),
            .in_is_ld     (in_is_ld),
            .in_is_st     (in_is_st),
            .in_size      (in_size),
            .in_uns       (in_uns),
            .in_addr      (in_addr),
            .in_wdata     (in_wdata),
            .in_rd        (in_rd),
            .in_wr_reg    (in_wr_reg),
            .in_result    (in_result),
            .in_pc        (in_pc),
            .out_valid    (o_valid[g]),
            .out_rd       (o_rd[g]),
            .out_wr_reg   (o_wr[g]),
            .out_val      (o_val[g]),
            .out_pc       (o_pc[g]),
            .out_misalign (o_mis[g]),
            .fwd_rd       (o_frd[g]),
            .fwd_wr       (o_fwr[g]),
`ifdef MEM_PERF_CNT_EN
            .ld_cnt       (o_ldc[g]),
            .st_cnt       (o_stc[g]),
            .stall_cnt    (o_stall[g]),
`endif
            .fwd_busy     (o_busy[g])
        );
    end

    logic        m_ready, m_valid, m_wr, m_mis, m_fwr, m_busy;
    logic [4:0]  m_rd, m_frd;
    logic [31:0] m_val, m_pc;
    assign m_ready = o_ready[sel];
    assign m_valid = o_valid[sel];
    assign m_wr    = o_wr[sel];
    assign m_mis   = o_mis[sel];
    assign m_fwr   = o_fwr[sel];
    assign m_busy  = o_busy[sel];
    assign m_rd    = o_rd[sel];
    assign m_frd   = o_frd[sel];
    assign m_val   = o_val[sel];
    assign m_pc    = o_pc[sel];

    typedef struct packed {
        logic [4:0]  rd;
        logic        wr;
        logic        mis;
        logic        chk_val;
        logic [31:0] val;
        logic [31:0] pc;
        logic [31:0] due;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every WB entry of the selected instance is popped and compared.
    always @(negedge clk) begin
        exp_t e;
        if (m_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got rd=%0d val=%h pc=%h at cyc %0d, required no entry",
                         m_rd, m_val, m_pc, cyc);
            end else begin
                e = exp_q.pop_front();
                if (m_rd !== e.rd || m_wr !== e.wr || m_mis !== e.mis || m_pc !== e.pc ||
                    32'(cyc) != e.due || (e.chk_val && m_val !== e.val)) begin
                    errors++;
                    $display("FAIL wb_entry: got rd=%0d wr=%0b mis=%0b val=%h pc=%h cyc=%0d, required rd=%0d wr=%0b mis=%0b val=%h(chk=%0b) pc=%h cyc=%0d",
                             m_rd, m_wr, m_mis, m_val, m_pc, cyc, e.rd, e.wr, e.mis, e.val, e.chk_val, e.pc, e.due);
                end
            end
        end
    end

    task automatic chk1(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0b, required %0b", name, got, req);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic drive(input int kind, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
        in_valid  = 1'b1;
        in_is_ld  = (kind == KL);
        in_is_st  = (kind == KS);
        in_size   = size;
        in_uns    = uns;
        in_addr   = addr;
        in_wdata  = data;
        in_result = data;
        in_rd     = rd;
        in_wr_reg = (kind != KS);
        in_pc     = pc_ctr;
        pc_ctr    = pc_ctr + 32'd4;
    endtask

    task automatic wait_accept(input logic [31:0] exp_val, input logic exp_mis,
                               input logic want_wb, output int acc);
        exp_t e;
        logic done;
        acc  = -1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (m_ready) begin
                done      = 1'b1;
                acc       = cyc;
                e.rd      = in_rd;
                e.wr      = in_wr_reg && !in_is_st && !exp_mis;
                e.mis     = exp_mis;
                e.chk_val = !in_is_st && !exp_mis;
                e.val     = exp_val;
                e.pc      = in_pc;
                e.due     = 32'(cyc + ((in_is_ld && !exp_mis) ? lat_of(sel) : 1));
                checks++;
                if (m_frd !== in_rd || m_fwr !== e.wr || m_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL fwd_accept: got rd=%0d wr=%0b busy=%0b, required rd=%0d wr=%0b busy=0",
                             m_frd, m_fwr, m_busy, in_rd, e.wr);
                end
                if (want_wb) exp_q.push_back(e);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 20 cycles, required acceptance");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_is_ld = 1'b0;
        in_is_st = 1'b0;
    endtask

    task automatic send(input int kind, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                        input logic [31:0] exp_val, input logic exp_mis);
        int acc;
        drive(kind, size, uns, addr, data, rd);
        wait_accept(exp_val, exp_mis, 1'b1, acc);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d entries outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int acc_ld, acc_add;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_out_valid", m_valid, 1'b0);
        chk1("rst_in_ready", m_ready, 1'b0);
        chk1("rst_fwd_busy", m_busy, 1'b0);
        chk1("rst_fwd_wr", m_fwr, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk1("post_rst_ready", m_ready, 1'b1);
        @(posedge clk);
        #1;

        // RD_LAT=1 instance: widths, extension, lanes, misalign, aliasing.
        sel = 0;
        send(KS, W, 0, 32'h100, 32'hDEADBEEF, 5'd1, 32'h0, 0);
        send(KL, W, 0, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0);
        send(KL, B, 0, 32'h103, 32'h0, 5'd6, 32'hFFFFFFDE, 0);
        send(KL, B, 1, 32'h103, 32'h0, 5'd7, 32'h000000DE, 0);
        send(KL, H, 0, 32'h102, 32'h0, 5'd8, 32'hFFFFDEAD, 0);
        send(KL, H, 1, 32'h100, 32'h0, 5'd9, 32'h0000BEEF, 0);
        send(KL, B, 0, 32'h100, 32'h0, 5'd10, 32'hFFFFFFEF, 0);
        send(KS, B, 0, 32'h101, 32'hABCDEF55, 5'd0, 32'h0, 0);
        send(KL, W, 0, 32'h100, 32'h0, 5'd11, 32'hDEAD55EF, 0);
        send(KA, W, 0, 32'h0, 32'h12345678, 5'd7, 32'h12345678, 0);
        idle(2);
        send(KL, W, 0, 32'h102, 32'h0, 5'd3, 32'h0, 1);
        send(KS, H, 0, 32'h101, 32'h0000AAAA, 5'd0, 32'h0, 1);
        send(KL, W, 0, 32'h100, 32'h0, 5'd12, 32'hDEAD55EF, 0);
        send(KS, H, 0, 32'h102, 32'h1234CAFE, 5'd0, 32'h0, 0);
        send(KL, W, 0, 32'h100, 32'h0, 5'd13, 32'hCAFE55EF, 0);
        send(KL, H, 0, 32'h102, 32'h0, 5'd14, 32'hFFFFCAFE, 0);
        send(KS, W, 0, 32'h2000, 32'h11223344, 5'd0, 32'h0, 0);
        send(KL, W, 0, 32'h0, 32'h0, 5'd15, 32'h11223344, 0);
        send(KS, B, 0, 32'h3, 32'h00000099, 5'd0, 32'h0, 0);
        send(KL, W, 0, 32'h2000, 32'h0, 5'd16, 32'h99223344, 0);
        drain();

        // RD_LAT=3 instance: load stalls the following ADD for two cycles.
        sel = 1;
        send(KS, W, 0, 32'h200, 32'hA5A5A5A5, 5'd0, 32'h0, 0);
        drive(KL, W, 0, 32'h200, 32'h0, 5'd9);
        wait_accept(32'hA5A5A5A5, 0, 1'b1, acc_ld);
        drive(KA, W, 0, 32'h0, 32'h00000042, 5'd10);
        repeat (2) begin
            @(negedge clk);
            chk1("wait_in_ready", m_ready, 1'b0);
            chk1("wait_fwd_busy", m_busy, 1'b1);
            chk32("wait_fwd_rd", 32'(m_frd), 32'd9);
        end
        wait_accept(32'h00000042, 0, 1'b1, acc_add);
        chk32("stall_len", 32'(acc_add - acc_ld), 32'd3);
        drain();
`ifdef MEM_PERF_CNT_EN
        chk32("stall_cnt", o_stall[1], 32'd2);
        chk32("ld_cnt_lat3", o_ldc[1], 32'd1);
        chk32("st_cnt_lat3", o_stc[1], 32'd2 - 32'd1);
        chk32("ld_cnt_lat1", o_ldc[0], 32'd13);
        chk32("st_cnt_lat1", o_stc[0], 32'd6);
        chk32("stall_cnt_lat1", o_stall[0], 32'd0);
`endif

        // RD_LAT=4 instance: reset during WAIT aborts the load.
        sel = 2;
        drive(KL, W, 0, 32'h300, 32'h0, 5'd11);
        wait_accept(32'h0, 0, 1'b0, acc_ld);
        @(negedge clk);
        chk1("wait4_busy", m_busy, 1'b1);
        chk1("wait4_ready", m_ready, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk1("abort_ready", m_ready, 1'b1);
        chk1("abort_out_valid", m_valid, 1'b0);
        chk1("abort_fwd_busy", m_busy, 1'b0);
        @(posedge clk);
        #1;
        idle(8);

        // A store held at the input while reset is high must not reach memory.
        sel = 0;
        drive(KS, W, 0, 32'h100, 32'h0BADF00D, 5'd0);
        reset = 1'b1;
        @(negedge clk);
        chk1("rst_store_ready", m_ready, 1'b0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_is_st = 1'b0;
        send(KL, W, 0, 32'h100, 32'h0, 5'd12, 32'hCAFE55EF, 0);
        drain();
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
